// File: rtl/firing_pkg.sv
// Shared definitions for the firing path: datapath command codes and the
// control-stage FSM encoding.
package firing_pkg;

    localparam logic [2:0] CTRL_RELOAD = 3'b000;
    localparam logic [2:0] CTRL_HOLD   = 3'b001;
    localparam logic [2:0] CTRL_SHOT   = 3'b011;
    localparam logic [2:0] CTRL_IDLE   = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_FIRE         = 3'd1,
        ST_COOLDOWN     = 3'd2,
        ST_WAIT_RELEASE = 3'd3,
        ST_RELOAD       = 3'd4
    } state_e;

    function automatic logic [2:0] ctrl_of(input state_e s);
        logic [2:0] c;
        case (s)
            ST_IDLE:   c = CTRL_IDLE;
            ST_FIRE:   c = CTRL_SHOT;
            ST_RELOAD: c = CTRL_RELOAD;
            default:   c = CTRL_HOLD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a saturating-agreement debouncer.
// active_o is the debounced input normalised to active-high.
module button_debounce #(
    parameter int CYCLES     = 500000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic active_o
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The stable value only moves after CYCLES consecutive disagreeing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= ACTIVE_LOW;
            sync2_q  <= ACTIVE_LOW;
            stable_q <= ACTIVE_LOW;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign active_o = stable_q ^ ACTIVE_LOW;

endmodule

// File: rtl/firing_control.sv
// Control stage for the firing datapath: turns the debounced trigger and
// reload switch into single-shot, cooldown, reload and dry-fire commands.
module firing_control
    import firing_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int COOLDOWN_CYCLES = 12500000,
    parameter int RELOAD_CYCLES   = 50000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       trigger_n,
    input  logic       reload_req,
    input  logic [1:0] shots_left,
    output logic [2:0] control,
    output logic       shot_pulse,
    output logic       dry_fire,
    output logic       busy
);

    localparam int CNT_MAX = (COOLDOWN_CYCLES > RELOAD_CYCLES) ? COOLDOWN_CYCLES : RELOAD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic             trig_active, reload_active;
    logic             trig_prev_q;
    logic             press;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dry_d;
    logic [2:0]       control_q;
    logic             shot_q, dry_q, busy_q;

    button_debounce #(.CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(1'b1)) u_trig_db (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw_i    (trigger_n),
        .active_o (trig_active)
    );

    button_debounce #(.CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(1'b0)) u_reload_db (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw_i    (reload_req),
        .active_o (reload_active)
    );

    assign press = trig_active & ~trig_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dry_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Reload outranks a simultaneous press, which is dropped.
                if (reload_active && (shots_left != 2'd3)) begin
                    state_d = ST_RELOAD;
                end else if (press) begin
                    if (shots_left != 2'd0) begin
                        state_d = ST_FIRE;
                    end else begin
                        dry_d   = 1'b1;
                        state_d = ST_WAIT_RELEASE;
                    end
                end
            end
            ST_FIRE: state_d = ST_COOLDOWN;
            ST_COOLDOWN: begin
                if (cnt_q == CNT_W'(COOLDOWN_CYCLES - 1)) state_d = ST_WAIT_RELEASE;
                else                                      cnt_d   = cnt_q + 1'b1;
            end
            ST_WAIT_RELEASE: begin
                if (!trig_active) state_d = ST_IDLE;
            end
            ST_RELOAD: begin
                if (cnt_q == CNT_W'(RELOAD_CYCLES - 1)) state_d = ST_WAIT_RELEASE;
                else                                    cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            trig_prev_q <= 1'b0;
            control_q   <= CTRL_IDLE;
            shot_q      <= 1'b0;
            dry_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            trig_prev_q <= trig_active;
            control_q   <= ctrl_of(state_d);
            shot_q      <= (state_d == ST_FIRE);
            dry_q       <= dry_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign control    = control_q;
    assign shot_pulse = shot_q;
    assign dry_fire   = dry_q;
    assign busy       = busy_q;

endmodule
